uart_tx_fifo: RTL and testbench

Parametrised transmit FIFO between the CPU/debug write ports and `uart_tx`. Accepts raw bytes and full-width words, which it expands into uppercase ASCII hex with an optional CR/LF. Drains one byte at a time into `uart_tx` using the existing baud-tick strobe/ready handshake. Successor to the fixed 256-byte TX buffer: configurable depth, true single-clock write strobes, full/overflow reporting, flush, and a built-in hex formatter.

---
 rtl/uart_tx_fifo.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding uart_tx: raw bytes plus a word-to-uppercase-hex formatter (optional CR/LF).
// Latency: byte write at N is visible in level/empty at N+1; earliest tx_strobe on the first baud tick at or after N+1.
// Backpressure: writes to a full FIFO are dropped and flagged sticky; the formatter stalls (never loses) on full or byte_en.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 8,
   parameter int WORD_W     = 32,
   parameter bit NEWLINE    = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  baud_x1,
   input  logic [7:0]            byte_data,
   input  logic                  byte_en,
   input  logic [WORD_W-1:0]     word_data,
   input  logic                  word_en,
   input  logic                  flush,
   output logic [7:0]            tx_data,
   output logic                  tx_strobe,
   input  logic                  tx_ready,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int NDIG  = WORD_W / 4;
   localparam int NCHR  = NDIG + (NEWLINE ? 2 : 0);
   localparam int CW    = $clog2(NCHR + 1);

   localparam logic [DEPTH_LOG2:0] DEPTH_V = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [CW-1:0]       NDIG_C  = CW'(NDIG);
   localparam logic [CW-1:0]       LAST_C  = CW'(NCHR - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STROBE = 2'd1,
      S_GAP    = 2'd2
   } state_t;

   // storage and pointers (one extra bit so full and empty are distinguishable)
   logic [7:0]          mem_q [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;

   // registered status
   logic [DEPTH_LOG2:0] level_q, level_d;
   logic                full_q, full_d;
   logic                empty_q, empty_d;
   logic                ovf_q, ovf_d;

   // formatter: word shifts left one nibble per emitted digit, cnt indexes the character
   logic                busy_q, busy_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [3:0]          nib;
   logic [7:0]          fmt_chr;

   // read side
   state_t              state_q, state_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_strobe_q, tx_strobe_d;
   logic [7:0]          rd_dat;

   // single write port arbitration result
   logic                wr_en;
   logic [7:0]          wr_dat;

   assign nib    = word_q[WORD_W-1 -: 4];
   assign rd_dat = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

   // character the formatter would emit this cycle: hex digit, then CR, then LF
   always_comb begin
      fmt_chr = 8'h0A;
      if (cnt_q < NDIG_C) begin
         fmt_chr = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
      end else if (cnt_q == NDIG_C) begin
         fmt_chr = 8'h0D;
      end
   end

   // write arbitration: byte_en wins, formatter fills idle write slots, full drops bytes
   always_comb begin
      wr_en    = 1'b0;
      wr_dat   = byte_data;
      wr_ptr_d = wr_ptr_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      word_d   = word_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         ovf_d    = 1'b0;
         busy_d   = 1'b0;
         cnt_d    = '0;
      end else begin
         if (byte_en) begin
            // a read in the same cycle cannot rescue a write against registered full
            if (full_q) begin
               ovf_d = 1'b1;
            end else begin
               wr_en  = 1'b1;
               wr_dat = byte_data;
            end
         end else if (busy_q && !full_q) begin
            wr_en  = 1'b1;
            wr_dat = fmt_chr;
            word_d = word_q << 4;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST_C) begin
               busy_d = 1'b0;
            end
         end
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         // a new word while still formatting the previous one is refused
         if (word_en) begin
            if (busy_q) begin
               ovf_d = 1'b1;
            end else begin
               busy_d = 1'b1;
               word_d = word_data;
               cnt_d  = '0;
            end
         end
      end
   end

   // read FSM: issue on a baud tick, hold strobe one baud period, then one gap tick for uart_tx to drop ready
   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      tx_data_d   = tx_data_q;
      tx_strobe_d = tx_strobe_q;
      if (flush) begin
         rd_ptr_d    = '0;
         tx_strobe_d = 1'b0;
         state_d     = S_IDLE;
      end else if (baud_x1) begin
         case (state_q)
            S_IDLE: begin
               if (!empty_q && tx_ready) begin
                  tx_data_d   = rd_dat;
                  rd_ptr_d    = rd_ptr_q + 1'b1;
                  tx_strobe_d = 1'b1;
                  state_d     = S_STROBE;
               end
            end
            S_STROBE: begin
               tx_strobe_d = 1'b0;
               state_d     = S_GAP;
            end
            S_GAP: begin
               state_d = S_IDLE;
            end
            default: begin
               tx_strobe_d = 1'b0;
               state_d     = S_IDLE;
            end
         endcase
      end
   end

   // status derived from next-cycle pointers so the outputs are registered yet current
   always_comb begin
      level_d = wr_ptr_d - rd_ptr_d;
      full_d  = (level_d == DEPTH_V);
      empty_d = (level_d == '0);
   end

   // state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         word_q      <= '0;
         cnt_q       <= '0;
         state_q     <= S_IDLE;
         tx_data_q   <= 8'h00;
         tx_strobe_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         ovf_q       <= ovf_d;
         busy_q      <= busy_d;
         word_q      <= word_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         tx_strobe_q <= tx_strobe_d;
      end
   end

   // byte storage; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_dat;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_strobe = tx_strobe_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign level     = level_q;
   assign overflow  = ovf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a queue-based reference model.
// Latency: checks status one cycle after each write; line bytes are compared as uart_tx accepts them.
// Backpressure: uart_tx stand-in holds ready low for a 10-tick frame after each accepted byte.
module tb_uart_tx_fifo;

   localparam int DL2      = 4;
   localparam int DEPTH    = 1 << DL2;
   localparam int BAUD_DIV = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          baud_x1 = 1'b0;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_en = 1'b0;
   logic [31:0]   word_data = 32'h0;
   logic          word_en = 1'b0;
   logic          flush = 1'b0;
   logic          tx_ready = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_strobe;
   logic          full;
   logic          empty;
   logic [DL2:0]  level;
   logic          overflow;
   logic          busy;

   int            checks = 0;
   int            errors = 0;

   // reference model: bytes accepted but not yet on the line, and characters the formatter still owes
   logic [7:0]    exp_q[$];
   logic [7:0]    fmt_q[$];
   bit            ovf_m = 1'b0;
   bit            exact = 1'b1;   // no reads possible, so model occupancy equals DUT level
   bit            hold = 1'b1;    // keeps uart_tx stand-in reporting not-ready
   int            ubusy = 0;
   int            bc = 0;

   uart_tx_fifo #(.DEPTH_LOG2(DL2), .WORD_W(32), .NEWLINE(1'b1)) dut (
      .clk(clk), .reset(reset), .baud_x1(baud_x1),
      .byte_data(byte_data), .byte_en(byte_en),
      .word_data(word_data), .word_en(word_en), .flush(flush),
      .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_ready(tx_ready),
      .full(full), .empty(empty), .level(level), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // baud tick generator plus uart_tx stand-in: takes a strobe on a baud tick, then busy for a frame
   always @(negedge clk) begin
      bc = (bc + 1) % BAUD_DIV;
      baud_x1 = (bc == 0);
      if (baud_x1 && !reset) begin
         if (ubusy > 0) begin
            ubusy--;
         end else if (tx_strobe) begin
            chk("line_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("line_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            ubusy = 10;
         end
      end
      tx_ready = (ubusy == 0) && !hold;
   end

   function automatic void load_word(input logic [31:0] w);
      for (int i = 7; i >= 0; i--) begin
         int n;
         n = int'((w >> (i * 4)) & 32'hF);
         fmt_q.push_back(n < 10 ? 8'(48 + n) : 8'(55 + n));
      end
      fmt_q.push_back(8'h0D);
      fmt_q.push_back(8'h0A);
   endfunction

   // one clock: drive inputs, advance the model by the rules of one write slot, compare after the edge
   task automatic step(input logic be, input logic [7:0] bd, input logic we, input logic [31:0] wd,
                       input logic fl);
      bit was_busy;
      byte_en = be; byte_data = bd; word_en = we; word_data = wd; flush = fl;
      was_busy = (fmt_q.size() != 0);
      if (fl) begin
         exp_q.delete();
         fmt_q.delete();
         ovf_m = 1'b0;
      end else begin
         if (be) begin
            if (exp_q.size() == DEPTH) ovf_m = 1'b1;
            else exp_q.push_back(bd);
         end else if (was_busy && exp_q.size() < DEPTH) begin
            exp_q.push_back(fmt_q.pop_front());
         end
         if (we) begin
            if (was_busy) ovf_m = 1'b1;
            else load_word(wd);
         end
      end
      @(posedge clk);
      #1;
      byte_en = 1'b0; word_en = 1'b0; flush = 1'b0;
      chk("overflow", 32'(overflow), 32'(ovf_m));
      if (exact) begin
         chk("busy", 32'(busy), 32'(fmt_q.size() != 0));
         chk("level", 32'(level), 32'(exp_q.size()));
         chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
         chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
   endtask

   // let the line run until everything owed has been sent; remaining formatter chars follow in order
   task automatic drain(input string tag);
      int n;
      n = 0;
      while (fmt_q.size() != 0) exp_q.push_back(fmt_q.pop_front());
      hold = 1'b0;
      exact = 1'b0;
      while ((exp_q.size() != 0 || !empty || tx_strobe || busy) && n < 4000) begin
         idle(1);
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < 4000), 32'd1);
      chk({tag, "_level0"}, 32'(level), 32'd0);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_notbusy"}, 32'(busy), 32'd0);
      hold = 1'b1;
      exact = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      int nb;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_tx_data", 32'(tx_data), 32'h00);
      chk("rst_tx_strobe", 32'(tx_strobe), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // ABC on consecutive clocks, level 1,2,3, then sent in order
      step(1'b1, 8'h41, 1'b0, 32'h0, 1'b0);
      step(1'b1, 8'h42, 1'b0, 32'h0, 1'b0);
      step(1'b1, 8'h43, 1'b0, 32'h0, 1'b0);
      chk("t1_level3", 32'(level), 32'd3);
      drain("t1");

      // formatter: "00C0FFEE\r\n", busy for exactly 10 clocks
      step(1'b0, 8'h00, 1'b1, 32'h00C0FFEE, 1'b0);
      nb = 0;
      while (busy && nb < 50) begin
         nb++;
         idle(1);
      end
      chk("t2_busy_len", 32'(nb), 32'd10);
      chk("t2_level", 32'(level), 32'd10);
      drain("t2");

      // byte_en on alternate clocks while formatting: stalls, no loss
      step(1'b0, 8'h00, 1'b1, 32'h12AB34CD, 1'b0);
      for (int i = 0; i < 8; i++) step(i % 2 == 0, 8'(8'h60 + i), 1'b0, 32'h0, 1'b0);
      idle(12);
      chk("t4_no_overflow", 32'(overflow), 32'd0);
      drain("t4");

      // second word while busy is refused and flagged
      step(1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b0);
      step(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 32'h55555555, 1'b0);
      idle(12);
      chk("t5_overflow", 32'(overflow), 32'd1);
      drain("t5");

      // fill past depth with uart_tx not ready: extras dropped
      for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 8'($urandom), 1'b0, 32'h0, 1'b0);
      chk("t3_full", 32'(full), 32'd1);
      chk("t3_level", 32'(level), 32'(DEPTH));
      drain("t3");

      // flush mid-transmission
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 32'h0, 1'b0);
      hold = 1'b0;
      exact = 1'b0;
      nb = 0;
      while (!tx_strobe && nb < 100) begin
         nb++;
         idle(1);
      end
      chk("t6_strobe_seen", 32'(tx_strobe), 32'd1);
      chk("t6_level_pre", 32'(level), 32'(exp_q.size() - 1));
      step(1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
      chk("t6_level0", 32'(level), 32'd0);
      chk("t6_empty", 32'(empty), 32'd1);
      chk("t6_overflow0", 32'(overflow), 32'd0);
      chk("t6_strobe0", 32'(tx_strobe), 32'd0);
      idle(60);
      step(1'b1, 8'h5A, 1'b0, 32'h0, 1'b0);
      drain("t6");

      // random traffic with occasional words and flushes; pointers wrap many times
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 30; c++) begin
            step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 39) == 0);
         end
         drain("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
